// File: rtl/miriscv_dmem_responder.sv
// Data-memory responder for the LSU data port: single outstanding request, fixed
// response latency, byte-lane stores and aligned/extended loads over a word RAM.
module miriscv_dmem_responder #(
    parameter int unsigned MEM_WORDS = 1024,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter int unsigned LATENCY   = 2
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        req_i,
    input  logic        we_i,
    input  logic [2:0]  size_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] wdata_i,
    output logic        gnt_o,
    output logic        rvalid_o,
    output logic [31:0] rdata_o,
    output logic        err_o
);

    localparam int unsigned IDX_W     = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;
    localparam int unsigned CNT_W     = 4;
    localparam logic [32:0] MEM_BYTES = 33'(MEM_WORDS) * 33'd4;

    localparam logic [2:0] SZ_WORD  = 3'd0;
    localparam logic [2:0] SZ_HALF  = 3'd1;
    localparam logic [2:0] SZ_BYTE  = 3'd2;
    localparam logic [2:0] SZ_UHALF = 3'd3;
    localparam logic [2:0] SZ_UBYTE = 3'd4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_e;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               accept, enter_resp;

    logic               we_q;
    logic [2:0]         size_q;
    logic [31:0]        addr_q, wdata_q;

    logic               op_we;
    logic [2:0]         op_size;
    logic [31:0]        op_addr, op_wdata;
    logic [32:0]        diff;
    logic [31:0]        off;
    logic [1:0]         lane;
    logic [IDX_W-1:0]   idx;
    logic               op_err;
    logic [3:0]         be;
    logic [31:0]        wdata_lanes;
    logic [31:0]        rd_word, rd_shift, rd_ext;

    logic [31:0]        mem [MEM_WORDS];

    // Next-state, grant and counter control
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        gnt_o      = 1'b0;
        accept     = 1'b0;
        enter_resp = 1'b0;
        case (state_q)
            ST_IDLE: begin
                gnt_o  = ~rst_i;
                accept = req_i & ~rst_i;
                if (accept) begin
                    if (LATENCY == 1) begin
                        state_d    = ST_RESP;
                        enter_resp = 1'b1;
                    end else begin
                        state_d = ST_WAIT;
                        cnt_d   = CNT_W'(LATENCY - 2);
                    end
                end
            end
            ST_WAIT: begin
                if (cnt_q == '0) begin
                    state_d    = ST_RESP;
                    enter_resp = ~rst_i;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            ST_RESP: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // With LATENCY=1 the operation executes on the accept edge, so use live inputs
    always_comb begin
        if (state_q == ST_IDLE) begin
            op_we    = we_i;
            op_size  = size_i;
            op_addr  = addr_i;
            op_wdata = wdata_i;
        end else begin
            op_we    = we_q;
            op_size  = size_q;
            op_addr  = addr_q;
            op_wdata = wdata_q;
        end
    end

    assign diff = {1'b0, op_addr} - {1'b0, BASE_ADDR};
    assign off  = diff[31:0];
    assign lane = off[1:0];
    assign idx  = off[IDX_W+1:2];

    // Legality: size code, alignment, store-unsigned and address window
    always_comb begin
        op_err = 1'b0;
        case (op_size)
            SZ_WORD:            op_err = (lane != 2'd0);
            SZ_HALF, SZ_UHALF:  op_err = lane[0];
            SZ_BYTE, SZ_UBYTE:  op_err = 1'b0;
            default:            op_err = 1'b1;
        endcase
        if (op_we && ((op_size == SZ_UHALF) || (op_size == SZ_UBYTE))) begin
            op_err = 1'b1;
        end
        if (diff[32] || ({1'b0, off} >= MEM_BYTES)) begin
            op_err = 1'b1;
        end
    end

    always_comb begin
        be          = 4'b0000;
        wdata_lanes = 32'h0;
        case (op_size)
            SZ_WORD: begin
                be          = 4'b1111;
                wdata_lanes = op_wdata;
            end
            SZ_HALF: begin
                be          = 4'b0011 << lane;
                wdata_lanes = {2{op_wdata[15:0]}};
            end
            SZ_BYTE: begin
                be          = 4'b0001 << lane;
                wdata_lanes = {4{op_wdata[7:0]}};
            end
            default: begin
                be          = 4'b0000;
                wdata_lanes = 32'h0;
            end
        endcase
    end

    always_comb begin
        rd_word  = mem[idx];
        rd_shift = rd_word >> {lane, 3'b000};
        case (op_size)
            SZ_WORD:  rd_ext = rd_shift;
            SZ_HALF:  rd_ext = {{16{rd_shift[15]}}, rd_shift[15:0]};
            SZ_UHALF: rd_ext = {16'h0, rd_shift[15:0]};
            SZ_BYTE:  rd_ext = {{24{rd_shift[7]}}, rd_shift[7:0]};
            SZ_UBYTE: rd_ext = {24'h0, rd_shift[7:0]};
            default:  rd_ext = 32'h0;
        endcase
    end

    // Byte-lane write on the edge entering RESP; array is not reset
    always_ff @(posedge clk_i) begin
        if (enter_resp && !rst_i && op_we && !op_err) begin
            for (int i = 0; i < 4; i++) begin
                if (be[i]) begin
                    mem[idx][8*i +: 8] <= wdata_lanes[8*i +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            rvalid_o <= 1'b0;
            err_o    <= 1'b0;
            rdata_o  <= 32'h0;
            we_q     <= 1'b0;
            size_q   <= 3'd0;
            addr_q   <= 32'h0;
            wdata_q  <= 32'h0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            rvalid_o <= enter_resp;
            if (accept) begin
                we_q    <= we_i;
                size_q  <= size_i;
                addr_q  <= addr_i;
                wdata_q <= wdata_i;
            end
            if (enter_resp) begin
                err_o   <= op_err;
                rdata_o <= (op_err || op_we) ? 32'h0 : rd_ext;
            end
        end
    end

endmodule

// File: tb/tb_miriscv_dmem_responder.sv
// Randomized bench for miriscv_dmem_responder: two instances (LATENCY=2, base 0 and
// LATENCY=1, base 0x100) checked against a byte-addressed little-endian memory model.
module tb_miriscv_dmem_responder;

    localparam int unsigned MW     = 256;
    localparam logic [31:0] BASE_B = 32'h0000_0100;

    localparam logic [2:0] SZ_WORD  = 3'd0;
    localparam logic [2:0] SZ_HALF  = 3'd1;
    localparam logic [2:0] SZ_BYTE  = 3'd2;
    localparam logic [2:0] SZ_UHALF = 3'd3;
    localparam logic [2:0] SZ_UBYTE = 3'd4;

    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst;

    logic        req_a, we_a, gnt_a, rvalid_a, err_a;
    logic [2:0]  size_a;
    logic [31:0] addr_a, wdata_a, rdata_a;
    logic        req_b, we_b, gnt_b, rvalid_b, err_b;
    logic [2:0]  size_b;
    logic [31:0] addr_b, wdata_b, rdata_b;

    miriscv_dmem_responder #(.MEM_WORDS(MW), .BASE_ADDR(32'h0), .LATENCY(2)) u_dut_a (
        .clk_i(clk), .rst_i(rst), .req_i(req_a), .we_i(we_a), .size_i(size_a),
        .addr_i(addr_a), .wdata_i(wdata_a), .gnt_o(gnt_a), .rvalid_o(rvalid_a),
        .rdata_o(rdata_a), .err_o(err_a)
    );

    miriscv_dmem_responder #(.MEM_WORDS(MW), .BASE_ADDR(BASE_B), .LATENCY(1)) u_dut_b (
        .clk_i(clk), .rst_i(rst), .req_i(req_b), .we_i(we_b), .size_i(size_b),
        .addr_i(addr_b), .wdata_i(wdata_b), .gnt_o(gnt_b), .rvalid_o(rvalid_b),
        .rdata_o(rdata_b), .err_o(err_b)
    );

    logic [7:0] mem_a [MW*4];
    logic [7:0] mem_b [MW*4];

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    endtask

    // Reference: returns {err, rdata}; applies stores to the byte model
    function automatic logic [32:0] model_op(input bit sel, input logic we, input logic [2:0] size,
                                             input logic [31:0] addr, input logic [31:0] wdata);
        longint a, b, off;
        int n;
        bit sgn, err;
        logic [31:0] v;
        a = addr;
        b = sel ? BASE_B : 32'h0;
        off = a - b;
        sgn = 1'b0;
        case (size)
            SZ_WORD:  n = 4;
            SZ_HALF:  begin n = 2; sgn = 1'b1; end
            SZ_BYTE:  begin n = 1; sgn = 1'b1; end
            SZ_UHALF: n = 2;
            SZ_UBYTE: n = 1;
            default:  n = 0;
        endcase
        if (n == 0) err = 1'b1;
        else err = (off < 0) || (off >= MW*4) || ((off % n) != 0) ||
                   (we && (size == SZ_UHALF || size == SZ_UBYTE));
        if (err) return {1'b1, 32'h0};
        if (we) begin
            for (int i = 0; i < n; i++) begin
                if (sel) mem_b[int'(off) + i] = wdata[8*i +: 8];
                else     mem_a[int'(off) + i] = wdata[8*i +: 8];
            end
            return {1'b0, 32'h0};
        end
        v = 32'h0;
        for (int i = 0; i < n; i++) v[8*i +: 8] = sel ? mem_b[int'(off) + i] : mem_a[int'(off) + i];
        if (sgn && n == 1 && v[7])  v = v | 32'hFFFF_FF00;
        if (sgn && n == 2 && v[15]) v = v | 32'hFFFF_0000;
        return {1'b0, v};
    endfunction

    task automatic drive(input bit sel, input logic req, input logic we, input logic [2:0] size,
                         input logic [31:0] addr, input logic [31:0] wdata);
        if (sel) begin req_b = req; we_b = we; size_b = size; addr_b = addr; wdata_b = wdata; end
        else     begin req_a = req; we_a = we; size_a = size; addr_a = addr; wdata_a = wdata; end
    endtask

    function automatic logic get_gnt(input bit sel);          return sel ? gnt_b : gnt_a;       endfunction
    function automatic logic get_rvalid(input bit sel);       return sel ? rvalid_b : rvalid_a; endfunction
    function automatic logic get_err(input bit sel);          return sel ? err_b : err_a;       endfunction
    function automatic logic [31:0] get_rdata(input bit sel); return sel ? rdata_b : rdata_a;   endfunction

    // One complete transaction; inputs are scrambled right after the accept edge
    task automatic txn(input bit sel, input logic we, input logic [2:0] size,
                       input logic [31:0] addr, input logic [31:0] wdata);
        logic [32:0] exp;
        int n;
        int lat;
        lat = sel ? 1 : 2;
        @(negedge clk);
        drive(sel, 1'b1, we, size, addr, wdata);
        n = 0;
        while (!get_gnt(sel) && n < 10) begin
            @(posedge clk); #1; n++;
        end
        if (n == 10) begin
            check_eq("gnt_timeout", 32'(get_gnt(sel)), 32'd1);
            drive(sel, 1'b0, 1'b0, 3'd0, 32'h0, 32'h0);
            return;
        end
        exp = model_op(sel, we, size, addr, wdata);
        @(posedge clk); #1;
        drive(sel, 1'b0, 1'($urandom), 3'($urandom), $urandom, $urandom);
        n = 1;
        while (!get_rvalid(sel) && n < 20) begin
            check_eq("gnt_busy", 32'(get_gnt(sel)), 32'd0);
            @(posedge clk); #1; n++;
        end
        check_eq("latency", 32'(n), 32'(lat));
        check_eq("gnt_resp", 32'(get_gnt(sel)), 32'd0);
        check_eq("err", 32'(get_err(sel)), 32'(exp[32]));
        check_eq("rdata", get_rdata(sel), exp[31:0]);
        @(posedge clk); #1;
        check_eq("rvalid_pulse", 32'(get_rvalid(sel)), 32'd0);
    endtask

    task automatic rand_txn(input bit sel);
        logic        we;
        logic [2:0]  size;
        logic [31:0] addr, base;
        base = sel ? BASE_B : 32'h0;
        we   = 1'($urandom_range(0, 1));
        size = ($urandom_range(0, 9) < 9) ? 3'($urandom_range(0, 4)) : 3'($urandom_range(5, 7));
        addr = base - 32'd8 + 32'($urandom_range(0, MW*4 + 15));
        if ($urandom_range(0, 3) != 0) begin
            if (size == SZ_WORD) addr[1:0] = 2'b00;
            else if (size == SZ_HALF || size == SZ_UHALF) addr[0] = 1'b0;
        end
        txn(sel, we, size, addr, $urandom);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic        ops_we   [3];
        logic [2:0]  ops_size [3];
        logic [31:0] ops_addr [3];
        logic [31:0] ops_wd   [3];
        logic [32:0] expq [$];
        int          accq [$];
        int          acc  [3];
        logic [32:0] e;
        int          a, k;
        bit          g;

        rst = 1'b1;
        drive(0, 0, 0, 0, 0, 0);
        drive(1, 0, 0, 0, 0, 0);
        repeat (2) @(negedge clk);
        #1;
        check_eq("rst_gnt_a", 32'(gnt_a), 32'd0);
        check_eq("rst_gnt_b", 32'(gnt_b), 32'd0);
        check_eq("rst_rvalid_a", 32'(rvalid_a), 32'd0);
        check_eq("rst_err_a", 32'(err_a), 32'd0);
        check_eq("rst_rdata_a", rdata_a, 32'h0);
        check_eq("rst_rvalid_b", 32'(rvalid_b), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check_eq("idle_gnt_a", 32'(gnt_a), 32'd1);

        for (int w = 0; w < MW; w++) txn(0, 1'b1, SZ_WORD, 32'(4*w), $urandom);
        for (int w = 0; w < MW; w++) txn(1, 1'b1, SZ_WORD, BASE_B + 32'(4*w), $urandom);

        txn(0, 1'b1, SZ_WORD, 32'h10, 32'hDEAD_BEEF);
        txn(0, 1'b0, SZ_WORD, 32'h10, 32'h0);
        check_eq("load_deadbeef", rdata_a, 32'hDEAD_BEEF);
        txn(0, 1'b1, SZ_BYTE, 32'h13, 32'hABCD_EF80);
        txn(0, 1'b0, SZ_BYTE, 32'h13, 32'h0);
        check_eq("load_byte_sext", rdata_a, 32'hFFFF_FF80);
        txn(0, 1'b0, SZ_UBYTE, 32'h13, 32'h0);
        check_eq("load_ubyte", rdata_a, 32'h0000_0080);
        txn(0, 1'b0, SZ_WORD, 32'h10, 32'h0);
        check_eq("lanes_untouched", rdata_a, 32'h80AD_BEEF);
        txn(0, 1'b1, SZ_HALF, 32'h22, 32'h1234_8001);
        txn(0, 1'b0, SZ_HALF, 32'h22, 32'h0);
        check_eq("load_half_sext", rdata_a, 32'hFFFF_8001);
        txn(0, 1'b0, SZ_UHALF, 32'h22, 32'h0);
        check_eq("load_uhalf", rdata_a, 32'h0000_8001);

        txn(0, 1'b0, SZ_WORD, 32'h11, 32'h0);
        check_eq("misaligned_err", 32'(err_a), 32'd1);
        txn(0, 1'b1, SZ_UBYTE, 32'h20, 32'hFFFF_FFFF);
        check_eq("store_ubyte_err", 32'(err_a), 32'd1);
        txn(0, 1'b0, 3'd5, 32'h20, 32'h0);
        check_eq("size5_err", 32'(err_a), 32'd1);
        txn(0, 1'b0, SZ_WORD, 32'(MW*4), 32'h0);
        check_eq("range_err", 32'(err_a), 32'd1);
        txn(0, 1'b0, SZ_WORD, 32'h20, 32'h0);

        // Reset while a store sits in WAIT
        txn(0, 1'b1, SZ_WORD, 32'h30, 32'hCAFE_F00D);
        @(negedge clk);
        drive(0, 1'b1, 1'b1, SZ_WORD, 32'h30, 32'h1234_5678);
        @(posedge clk); #1;
        drive(0, 1'b0, 1'b0, 3'd0, 32'h0, 32'h0);
        check_eq("gnt_wait", 32'(gnt_a), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check_eq("gnt_in_rst", 32'(gnt_a), 32'd0);
        @(posedge clk); #1;
        check_eq("rvalid_after_rst", 32'(rvalid_a), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check_eq("gnt_after_rst", 32'(gnt_a), 32'd1);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            check_eq("no_rvalid_dropped", 32'(rvalid_a), 32'd0);
        end
        txn(0, 1'b0, SZ_WORD, 32'h30, 32'h0);
        check_eq("dropped_store", rdata_a, 32'hCAFE_F00D);

        // LATENCY=1 with req_i held high across three requests
        ops_we[0] = 1'b1; ops_size[0] = SZ_WORD; ops_addr[0] = BASE_B + 32'h40; ops_wd[0] = 32'h1357_9BDF;
        ops_we[1] = 1'b0; ops_size[1] = SZ_WORD; ops_addr[1] = BASE_B + 32'h40; ops_wd[1] = 32'h0;
        ops_we[2] = 1'b0; ops_size[2] = SZ_BYTE; ops_addr[2] = BASE_B + 32'h43; ops_wd[2] = 32'h0;
        k = 0;
        @(negedge clk);
        drive(1, 1'b1, ops_we[0], ops_size[0], ops_addr[0], ops_wd[0]);
        g = gnt_b;
        for (int c = 0; c < 30 && (k < 3 || expq.size() > 0); c++) begin
            @(posedge clk); #1;
            if (g && k < 3) begin
                expq.push_back(model_op(1, ops_we[k], ops_size[k], ops_addr[k], ops_wd[k]));
                accq.push_back(c);
                acc[k] = c;
                k++;
                if (k < 3) drive(1, 1'b1, ops_we[k], ops_size[k], ops_addr[k], ops_wd[k]);
                else       drive(1, 1'b0, 1'b0, 3'd0, 32'h0, 32'h0);
            end
            if (rvalid_b) begin
                if (expq.size() == 0) begin
                    check_eq("spurious_rvalid_b", 32'd1, 32'd0);
                end else begin
                    e = expq.pop_front();
                    a = accq.pop_front();
                    check_eq("held_latency", 32'(c), 32'(a));
                    check_eq("held_err", 32'(err_b), 32'(e[32]));
                    check_eq("held_rdata", rdata_b, e[31:0]);
                end
            end
            g = gnt_b;
        end
        check_eq("held_accepts", 32'(k), 32'd3);
        check_eq("held_spacing_1", 32'(acc[1] - acc[0]), 32'd2);
        check_eq("held_spacing_2", 32'(acc[2] - acc[1]), 32'd2);
        check_eq("held_byte_sext", rdata_b, 32'h0000_0013);

        for (int i = 0; i < 300; i++) rand_txn(0);
        for (int i = 0; i < 150; i++) rand_txn(1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
